// File: rtl/program_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// master = byte source (e.g. UART receiver), slave = loader.
interface program_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: packs a length-prefixed little-endian byte stream into halfwords
// and writes them to instruction memory, holding the core in reset until loaded.
// Optional feature: define CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
   parameter int unsigned PROG_ADDR_WIDTH = 7,
   parameter int unsigned HALF_WIDTH      = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   program_loader_if.slave            stream,
   output logic                       mem_write_en,
   output logic [HALF_WIDTH-1:0]      mem_write_data,
   output logic [PROG_ADDR_WIDTH-1:0] mem_address,
   output logic                       core_hold,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   localparam int unsigned MAX_HALVES = 2 ** (PROG_ADDR_WIDTH - 1);
   localparam int unsigned LEN_W      = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA_LO,
      S_DATA_HI,
`ifdef CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state;
   logic [7:0]       len_lo;
   logic [7:0]       data_lo;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] hw_cnt;
   logic             accept;
   logic [LEN_W-1:0] len_full;
`ifdef CHECKSUM_EN
   logic [7:0]       csum;
`endif

   assign accept   = stream.in_valid && stream.in_ready;
   assign len_full = {stream.in_data, len_lo};

   // Single-process FSM; every transition sets the registered status outputs for the
   // state being entered so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         stream.in_ready <= 1'b0;
         mem_write_en    <= 1'b0;
         mem_write_data  <= '0;
         mem_address     <= '0;
         core_hold       <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         len_lo          <= '0;
         data_lo         <= '0;
         len             <= '0;
         hw_cnt          <= '0;
`ifdef CHECKSUM_EN
         csum            <= '0;
`endif
      end else begin
         mem_write_en <= 1'b0;
         if (mem_write_en) begin
            mem_address <= mem_address + PROG_ADDR_WIDTH'(2);
         end

         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state           <= S_LEN_LO;
                  stream.in_ready <= 1'b1;
                  busy            <= 1'b1;
                  core_hold       <= 1'b1;
                  done            <= 1'b0;
                  error           <= 1'b0;
                  mem_address     <= '0;
                  hw_cnt          <= '0;
`ifdef CHECKSUM_EN
                  csum            <= '0;
`endif
               end
            end

            S_LEN_LO: begin
               if (accept) begin
                  len_lo <= stream.in_data;
                  state  <= S_LEN_HI;
               end
            end

            S_LEN_HI: begin
               if (accept) begin
                  len <= len_full;
                  if (len_full == '0) begin
`ifdef CHECKSUM_EN
                     state           <= S_CSUM;
`else
                     state           <= S_DONE;
                     stream.in_ready <= 1'b0;
                     busy            <= 1'b0;
                     done            <= 1'b1;
                     core_hold       <= 1'b0;
`endif
                  end else if (32'(len_full) > MAX_HALVES) begin
                     // Image would not fit: refuse before any write happens.
                     state           <= S_ERROR;
                     stream.in_ready <= 1'b0;
                     busy            <= 1'b0;
                     error           <= 1'b1;
                  end else begin
                     state <= S_DATA_LO;
                  end
               end
            end

            S_DATA_LO: begin
               if (accept) begin
                  data_lo <= stream.in_data;
                  state   <= S_DATA_HI;
`ifdef CHECKSUM_EN
                  csum    <= csum ^ stream.in_data;
`endif
               end
            end

            S_DATA_HI: begin
               if (accept) begin
                  mem_write_en   <= 1'b1;
                  mem_write_data <= HALF_WIDTH'({stream.in_data, data_lo});
                  hw_cnt         <= hw_cnt + LEN_W'(1);
`ifdef CHECKSUM_EN
                  csum           <= csum ^ stream.in_data;
`endif
                  if (hw_cnt + LEN_W'(1) == len) begin
`ifdef CHECKSUM_EN
                     state           <= S_CSUM;
`else
                     state           <= S_DONE;
                     stream.in_ready <= 1'b0;
                     busy            <= 1'b0;
                     done            <= 1'b1;
                     core_hold       <= 1'b0;
`endif
                  end else begin
                     state <= S_DATA_LO;
                  end
               end
            end

`ifdef CHECKSUM_EN
            S_CSUM: begin
               if (accept) begin
                  stream.in_ready <= 1'b0;
                  busy            <= 1'b0;
                  if (stream.in_data == csum) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state           <= S_IDLE;
               stream.in_ready <= 1'b0;
               busy            <= 1'b0;
               core_hold       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (default PROG_ADDR_WIDTH=7).
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mem_write_en;
   logic [15:0] mem_write_data;
   logic [6:0]  mem_address;
   logic        core_hold, busy, done, error;

   program_loader_if bus ();

   program_loader #(.PROG_ADDR_WIDTH(7), .HALF_WIDTH(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .stream         (bus),
      .mem_write_en   (mem_write_en),
      .mem_write_data (mem_write_data),
      .mem_address    (mem_address),
      .core_hold      (core_hold),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [6:0]  wr_addr[$];
   logic [15:0] wr_data[$];

   // Record every cycle the write strobe is high.
   always @(negedge clk) begin
      if (mem_write_en === 1'b1) begin
         wr_addr.push_back(mem_address);
         wr_data.push_back(mem_write_data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n = 0;
      if (gaps) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL send_byte timeout: in_ready=%b expected 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic check_idle(input string tag, input bit exp_done, input bit exp_err);
      chk({tag, " done"},      32'(done),      32'(exp_done));
      chk({tag, " error"},     32'(error),     32'(exp_err));
      chk({tag, " core_hold"}, 32'(core_hold), 32'(!exp_done));
      chk({tag, " busy"},      32'(busy),      32'd0);
      chk({tag, " in_ready"},  32'(bus.in_ready), 32'd0);
   endtask

   typedef struct packed {
      logic [63:0] bytes;
      logic [3:0]  nb;
      logic [1:0]  nwr;
      logic [31:0] wd;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0] cs;
      logic [7:0] b;
      int nw;

      reset = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst core_hold",    32'(core_hold),    32'd1);
      chk("rst in_ready",     32'(bus.in_ready), 32'd0);
      chk("rst done",         32'(done),         32'd0);
      chk("rst error",        32'(error),        32'd0);
      chk("rst mem_write_en", 32'(mem_write_en), 32'd0);
      chk("rst busy",         32'(busy),         32'd0);
      chk("rst mem_address",  32'(mem_address),  32'd0);
      reset = 1'b0;
      @(negedge clk);

      // bytes listed low byte first: byte j = bytes[8*j +: 8]
      vecs[0] = '{bytes: 64'h0000_0093_0013_0002, nb: 4'd6, nwr: 2'd2,
                  wd: 32'h0093_0013, exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{bytes: 64'h0000_0000_0000_0000, nb: 4'd2, nwr: 2'd0,
                  wd: 32'h0, exp_done: 1'b1, exp_err: 1'b0};
      vecs[2] = '{bytes: 64'h0000_0000_0000_0041, nb: 4'd2, nwr: 2'd0,
                  wd: 32'h0, exp_done: 1'b0, exp_err: 1'b1};
      vecs[3] = '{bytes: 64'h0000_0000_1234_0001, nb: 4'd4, nwr: 2'd1,
                  wd: 32'h0000_1234, exp_done: 1'b1, exp_err: 1'b0};
      vecs[4] = '{bytes: 64'h0000_0000_0000_0100, nb: 4'd2, nwr: 2'd0,
                  wd: 32'h0, exp_done: 1'b0, exp_err: 1'b1};

      for (int i = 0; i < 5; i++) begin
         clear_log();
         pulse_start();
         chk($sformatf("v%0d start busy", i),      32'(busy),      32'd1);
         chk($sformatf("v%0d start done", i),      32'(done),      32'd0);
         chk($sformatf("v%0d start error", i),     32'(error),     32'd0);
         chk($sformatf("v%0d start core_hold", i), 32'(core_hold), 32'd1);
         cs = 8'h00;
         for (int j = 0; j < int'(vecs[i].nb); j++) begin
            b = vecs[i].bytes[8*j +: 8];
            if (j >= 2) cs = cs ^ b;
            send_byte(b, 1'b0);
         end
`ifdef CHECKSUM_EN
         if (!vecs[i].exp_err) send_byte(cs, 1'b0);
`endif
         repeat (3) @(negedge clk);
         check_idle($sformatf("v%0d", i), vecs[i].exp_done, vecs[i].exp_err);
         chk($sformatf("v%0d nwrites", i), 32'(wr_data.size()), 32'(vecs[i].nwr));
         for (int k = 0; k < int'(vecs[i].nwr) && k < wr_data.size(); k++) begin
            chk($sformatf("v%0d wdata%0d", i, k), 32'(wr_data[k]), 32'(vecs[i].wd[16*k +: 16]));
            chk($sformatf("v%0d waddr%0d", i, k), 32'(wr_addr[k]), 32'(2 * k));
         end
      end

`ifdef CHECKSUM_EN
      // Wrong checksum byte: data written, then error
      clear_log();
      pulse_start();
      send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h81, 1'b0);
      repeat (2) @(negedge clk);
      check_idle("badcsum", 1'b0, 1'b1);
      chk("badcsum nwrites", 32'(wr_data.size()), 32'd2);
`endif

      // Random in_valid gaps and a start pulse while busy
      clear_log();
      pulse_start();
      send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h13, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h00, 1'b1); send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
`ifdef CHECKSUM_EN
      send_byte(8'h80, 1'b1);
`endif
      repeat (3) @(negedge clk);
      check_idle("gaps", 1'b1, 1'b0);
      chk("gaps nwrites", 32'(wr_data.size()), 32'd2);
      if (wr_data.size() == 2) begin
         chk("gaps wdata0", 32'(wr_data[0]), 32'h0013);
         chk("gaps waddr0", 32'(wr_addr[0]), 32'd0);
         chk("gaps wdata1", 32'(wr_data[1]), 32'h0093);
         chk("gaps waddr1", 32'(wr_addr[1]), 32'd2);
      end

      // Maximum length 64: every address 0..126, last write coincides with DONE
      clear_log();
      pulse_start();
      send_byte(8'h40, 1'b0); send_byte(8'h00, 1'b0);
      cs = 8'h00;
      for (int k = 0; k < 64; k++) begin
         send_byte(8'(k), 1'b0);
         cs = cs ^ 8'(k) ^ 8'hA0;
         send_byte(8'hA0, 1'b0);
      end
`ifndef CHECKSUM_EN
      chk("max last we",        32'(mem_write_en), 32'd1);
      chk("max last core_hold", 32'(core_hold),    32'd0);
`else
      send_byte(cs, 1'b0);
`endif
      repeat (3) @(negedge clk);
      check_idle("max", 1'b1, 1'b0);
      chk("max nwrites", 32'(wr_data.size()), 32'd64);
      nw = 0;
      for (int k = 0; k < 64 && k < wr_data.size(); k++) begin
         if (wr_data[k] !== {8'hA0, 8'(k)} || wr_addr[k] !== 7'(2 * k)) nw++;
      end
      chk("max write contents errors", 32'(nw), 32'd0);

      // start with in_valid in same IDLE cycle: that byte is not consumed
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clear_log();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bus.in_valid = 1'b0;
      chk("startv busy", 32'(busy), 32'd1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
`ifndef CHECKSUM_EN
      chk("zero done next cycle", 32'(done), 32'd1);
`else
      send_byte(8'h00, 1'b0);
`endif
      repeat (2) @(negedge clk);
      check_idle("startv", 1'b1, 1'b0);
      chk("startv nwrites", 32'(wr_data.size()), 32'd0);

      // Reset mid-load after one halfword and one DATA_LO byte
      clear_log();
      pulse_start();
      send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst in_ready",     32'(bus.in_ready), 32'd0);
      chk("midrst mem_write_en", 32'(mem_write_en), 32'd0);
      chk("midrst mem_address",  32'(mem_address),  32'd0);
      chk("midrst core_hold",    32'(core_hold),    32'd1);
      chk("midrst busy",         32'(busy),         32'd0);
      chk("midrst done",         32'(done),         32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst nwrites", 32'(wr_data.size()), 32'd1);
      clear_log();
      pulse_start();
      send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
`ifdef CHECKSUM_EN
      send_byte(8'h33, 1'b0);
`endif
      repeat (3) @(negedge clk);
      check_idle("reload", 1'b1, 1'b0);
      chk("reload nwrites", 32'(wr_data.size()), 32'd1);
      if (wr_data.size() == 1) begin
         chk("reload wdata", 32'(wr_data[0]), 32'h6655);
         chk("reload waddr", 32'(wr_addr[0]), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
